// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative
// non-restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_CORR,
    S_HOLD
  } div_state_t;

  // Widest operand the magnitude helper handles.
  localparam int MAG_MAX_W = 64;

  // Index register width for a W-bit divider.
  function automatic int idx_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // Magnitude of a sign-extended operand.
  // The result is one bit wider than the value,
  // so the most negative value has a magnitude.
  function automatic logic [MAG_MAX_W:0] abs_mag(
    input logic [MAG_MAX_W-1:0] value,
    input logic                 signed_mode
  );
    logic [MAG_MAX_W:0] ext;
    ext = {signed_mode & value[MAG_MAX_W-1], value};
    if (signed_mode && value[MAG_MAX_W-1])
      return -ext;
    return ext;
  endfunction

endpackage

// File: rtl/nonrestoring_divider_v2_0_iter.sv
// Non-restoring datapath: partial remainder,
// shifted divisor, quotient digits and correction.
module nr_div_iter_v2_0 #(
  parameter int W     = 12,
  parameter int IDX_W = 5
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic         finish,
  input  logic [W:0]   num_mag,
  input  logic [W:0]   den_mag,
  output logic         last,
  output logic [W-1:0] quo_mag,
  output logic [W-1:0] rem_mag
);

  logic [2*W:0]   part;
  logic [2*W:0]   dvs;
  logic [W-1:0]   digits;
  logic [IDX_W-1:0] idx;

  logic           neg;
  logic [2*W:0]   nxt;
  logic [2*W:0]   fixed;
  logic           unused_fixed;

  // One add/subtract step and the final correction.
  always_comb begin
    neg   = part[2*W];
    nxt   = neg ? {part[2*W-1:0], 1'b0} + dvs
                : {part[2*W-1:0], 1'b0} - dvs;
    fixed = neg ? part + dvs : part;
    // q - ~q == 2q + 1; one less when R ended negative.
    quo_mag = {digits[W-2:0], 1'b1}
            - {{(W-1){1'b0}}, neg};
    rem_mag = fixed[2*W-1:W];
    last    = (idx == '0);
    unused_fixed = ^{fixed[2*W], fixed[W-1:0],
                     digits[W-1]};
  end

  // Working registers; cleared once the result is taken.
  always_ff @(posedge aclk) begin
    if (reset || finish) begin
      part   <= '0;
      dvs    <= '0;
      digits <= '0;
      idx    <= '0;
    end else if (load) begin
      part   <= {{W{1'b0}}, num_mag};
      dvs    <= {den_mag, {W{1'b0}}};
      digits <= '0;
      idx    <= IDX_W'(W - 1);
    end else if (step) begin
      part   <= nxt;
      digits <= {digits[W-2:0], ~neg};
      idx    <= idx - 1'b1;
    end
  end

endmodule

// File: rtl/nonrestoring_divider_v2_0.sv
// Signed/unsigned iterative divider with
// valid/ready handshakes on both sides.
module nonrestoring_divider_v2_0
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int SIGNED_EN  = 1,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_signed,
  input  logic [DATA_WIDTH-1:0] s_numerator,
  input  logic [DATA_WIDTH-1:0] s_denominator,
  input  logic [TAG_WIDTH-1:0]  s_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_quotient,
  output logic [DATA_WIDTH-1:0] m_remainder,
  output logic [TAG_WIDTH-1:0]  m_tag,
  output logic                  m_div0,
  output logic                  m_overflow
);

  localparam int W     = DATA_WIDTH;
  localparam int IDX_W = idx_width(DATA_WIDTH);

  div_state_t state, state_nxt;

  logic [W-1:0]         num;
  logic [W-1:0]         den;
  logic [TAG_WIDTH-1:0] tag;
  logic                 sgn;
  logic                 neg_q;
  logic                 neg_r;
  logic [W-1:0]         quotient;
  logic [W-1:0]         remainder;
  logic                 div0;
  logic                 ovf;

  logic                 is_div0;
  logic                 is_ovf;
  logic                 load;
  logic                 step;
  logic                 finish;
  logic                 last;
  logic [MAG_MAX_W-1:0] num_ext;
  logic [MAG_MAX_W-1:0] den_ext;
  logic [MAG_MAX_W:0]   num_abs;
  logic [MAG_MAX_W:0]   den_abs;
  logic [W-1:0]         quo_mag;
  logic [W-1:0]         rem_mag;
  logic                 unused_mag;

  // Special-case detection and operand magnitudes.
  always_comb begin
    is_div0 = (den == '0);
    is_ovf  = sgn
           && (num == {1'b1, {(W-1){1'b0}}})
           && (den == '1);
    num_ext = {{(MAG_MAX_W-W){sgn & num[W-1]}}, num};
    den_ext = {{(MAG_MAX_W-W){sgn & den[W-1]}}, den};
    num_abs = abs_mag(num_ext, sgn);
    den_abs = abs_mag(den_ext, sgn);
    unused_mag = ^{num_abs[MAG_MAX_W:W+1],
                   den_abs[MAG_MAX_W:W+1]};
  end

  nr_div_iter_v2_0 #(
    .W     (W),
    .IDX_W (IDX_W)
  ) u_iter (
    .aclk    (aclk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .finish  (finish),
    .num_mag (num_abs[W:0]),
    .den_mag (den_abs[W:0]),
    .last    (last),
    .quo_mag (quo_mag),
    .rem_mag (rem_mag)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshakes and datapath controls.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      S_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = S_PREP;
      end
      S_PREP: begin
        if (is_div0 || is_ovf) begin
          state_nxt = S_HOLD;
        end else begin
          load      = 1'b1;
          state_nxt = S_ITER;
        end
      end
      S_ITER: begin
        step = 1'b1;
        if (last) state_nxt = S_CORR;
      end
      S_CORR: begin
        finish    = 1'b1;
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, sign bookkeeping and result regs.
  always_ff @(posedge aclk) begin
    if (reset) begin
      num       <= '0;
      den       <= '0;
      tag       <= '0;
      sgn       <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (s_valid) begin
            num <= s_numerator;
            den <= s_denominator;
            tag <= s_tag;
            sgn <= (SIGNED_EN != 0) && s_signed;
          end
        end
        S_PREP: begin
          neg_q <= sgn & (num[W-1] ^ den[W-1]);
          neg_r <= sgn & num[W-1];
          if (is_div0) begin
            quotient  <= '1;
            remainder <= num;
            div0      <= 1'b1;
          end else if (is_ovf) begin
            quotient  <= num;
            remainder <= '0;
            ovf       <= 1'b1;
          end
        end
        S_CORR: begin
          quotient  <= neg_q ? -quo_mag : quo_mag;
          remainder <= neg_r ? -rem_mag : rem_mag;
        end
        S_HOLD: begin
          if (m_ready) begin
            div0 <= 1'b0;
            ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_quotient  = quotient;
  assign m_remainder = remainder;
  assign m_tag       = tag;
  assign m_div0      = div0;
  assign m_overflow  = ovf;

endmodule

// File: tb/tb_nonrestoring_divider_v2_0.sv
// Scoreboard bench for the non-restoring divider
// against a native truncating-division model.
module tb_nonrestoring_divider_v2_0;

  localparam int W  = 12;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    logic          dz;
    logic          ov;
  } exp_t;

  logic          aclk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic          s_signed;
  logic [W-1:0]  s_numerator;
  logic [W-1:0]  s_denominator;
  logic [TW-1:0] s_tag;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_quotient;
  logic [W-1:0]  m_remainder;
  logic [TW-1:0] m_tag;
  logic          m_div0;
  logic          m_overflow;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 aclk = ~aclk;

  nonrestoring_divider_v2_0 #(
    .DATA_WIDTH (W),
    .SIGNED_EN  (1),
    .TAG_WIDTH  (TW)
  ) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_signed      (s_signed),
    .s_numerator   (s_numerator),
    .s_denominator (s_denominator),
    .s_tag         (s_tag),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_quotient    (m_quotient),
    .m_remainder   (m_remainder),
    .m_tag         (m_tag),
    .m_div0        (m_div0),
    .m_overflow    (m_overflow)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] n,
                                 input logic [W-1:0] d,
                                 input logic sg,
                                 input logic [TW-1:0] t);
    exp_t e;
    int   a;
    int   b;
    e = '0;
    e.tag = t;
    if (d == 0) begin
      e.q  = '1;
      e.r  = n;
      e.dz = 1'b1;
    end else if (sg && n == 12'h800 && d == 12'hFFF) begin
      e.q  = 12'h800;
      e.r  = '0;
      e.ov = 1'b1;
    end else begin
      if (sg) begin
        a = {{20{n[W-1]}}, n};
        b = {{20{d[W-1]}}, d};
      end else begin
        a = {20'b0, n};
        b = {20'b0, d};
      end
      e.q = 12'(a / b);
      e.r = 12'(a % b);
    end
    return e;
  endfunction

  // Offer one operation; returns just after it is taken.
  task automatic send(input logic [W-1:0] n,
                      input logic [W-1:0] d,
                      input logic sg,
                      input logic [TW-1:0] t);
    int guard;
    s_numerator   = n;
    s_denominator = d;
    s_signed      = sg;
    s_tag         = t;
    s_valid       = 1'b1;
    guard = 0;
    while (!s_ready && guard < 200) begin
      @(posedge aclk); #1;
      guard++;
    end
    if (!s_ready) check("s_ready_timeout", 0, 1);
    @(posedge aclk); #1;
    s_valid = 1'b0;
  endtask

  task automatic push_send(input logic [W-1:0] n,
                           input logic [W-1:0] d,
                           input logic sg,
                           input logic [TW-1:0] t);
    sb.push_back(model(n, d, sg, t));
    send(n, d, sg, t);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 60) begin
      @(posedge aclk); #1;
      lat++;
    end
  endtask

  // Compare every completed result with the scoreboard.
  always @(negedge aclk) begin
    exp_t e;
    if (!reset && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", 32'(m_quotient), 32'(e.q));
        check("remainder", 32'(m_remainder), 32'(e.r));
        check("tag", 32'(m_tag), 32'(e.tag));
        check("div0", 32'(m_div0), 32'(e.dz));
        check("overflow", 32'(m_overflow), 32'(e.ov));
      end
    end
  end

  initial begin
    int lat;
    int seen;
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic sg;
    int kind;

    reset         = 1'b1;
    s_valid       = 1'b0;
    s_signed      = 1'b0;
    s_numerator   = '0;
    s_denominator = '0;
    s_tag         = '0;
    m_ready       = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    reset = 1'b0;
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_quotient", 32'(m_quotient), 0);
    check("rst_remainder", 32'(m_remainder), 0);
    check("rst_tag", 32'(m_tag), 0);
    check("rst_flags", 32'({m_div0, m_overflow}), 0);

    push_send(12'd100, 12'd7, 1'b0, 4'h1);
    wait_valid(lat);
    check("lat_unsigned", lat, 14);
    @(posedge aclk); #1;
    check("s_ready_back", 32'(s_ready), 1);

    push_send(12'hF9C, 12'd7, 1'b1, 4'h2);
    wait_valid(lat);
    check("lat_signed", lat, 14);
    push_send(12'd100, 12'hFF9, 1'b1, 4'h3);
    wait_valid(lat);
    push_send(12'hFFF, 12'h001, 1'b0, 4'h4);
    wait_valid(lat);

    push_send(12'd55, 12'd0, 1'b0, 4'h5);
    wait_valid(lat);
    check("lat_div0", lat, 1);
    push_send(12'd55, 12'd0, 1'b1, 4'h6);
    wait_valid(lat);
    push_send(12'h800, 12'hFFF, 1'b1, 4'h7);
    wait_valid(lat);
    check("lat_ovf", lat, 1);
    @(posedge aclk); #1;

    m_ready = 1'b0;
    push_send(12'd100, 12'd7, 1'b0, 4'h8);
    wait_valid(lat);
    check("lat_bp", lat, 14);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(m_valid), 1);
      check("bp_s_ready", 32'(s_ready), 0);
      check("bp_quotient", 32'(m_quotient), 14);
      check("bp_tag", 32'(m_tag), 8);
      @(posedge aclk); #1;
    end
    m_ready = 1'b1;
    @(posedge aclk); #1;
    check("bp_valid_drop", 32'(m_valid), 0);
    check("bp_s_ready_back", 32'(s_ready), 1);

    send(12'd100, 12'd7, 1'b0, 4'h9);
    repeat (5) @(posedge aclk);
    #1;
    reset = 1'b1;
    @(posedge aclk); #1;
    reset = 1'b0;
    check("abort_s_ready", 32'(s_ready), 1);
    check("abort_m_valid", 32'(m_valid), 0);
    seen = 0;
    repeat (20) begin
      @(posedge aclk); #1;
      if (m_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    push_send(12'd9, 12'd3, 1'b0, 4'hA);
    wait_valid(lat);
    check("lat_after_abort", lat, 14);

    for (int i = 0; i < 1000; i++) begin
      kind = $urandom_range(0, 19);
      n  = 12'($urandom_range(0, 4095));
      d  = 12'($urandom_range(0, 4095));
      sg = 1'($urandom_range(0, 1));
      if (kind == 0) d = '0;
      else if (kind == 1) begin
        n  = 12'h800;
        d  = 12'hFFF;
        sg = 1'b1;
      end else if (kind < 5) d = 12'($urandom_range(1, 3));
      push_send(n, d, sg, 4'(i));
    end

    seen = 0;
    while (sb.size() != 0 && seen < 100) begin
      @(posedge aclk); #1;
      seen++;
    end
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
